cordic_iter_controller: RTL

//  Sequencing stage directly upstream of the Cordic core.
//  - Accepts one job: initial x/y/z, rotation system, control mode and iteration count.
//  - Loads the core, issues one iterate step per cycle with the correct shift index,
//    and tracks sticky overflow plus the first-overflow iteration.
//  - Returns the final x/y/z to the consumer over a valid/ready handshake.

---
 rtl/cordic_iter_controller_if.sv | 58 +++++
 rtl/cordic_iter_controller.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/cordic_iter_controller_if.sv
// Job, core and result signals of the CORDIC iteration controller.
// The controller uses the master modport; its environment uses the slave modport.
interface cordic_iter_controller_if #(
    parameter int p_WIDTH  = 32,
    parameter int p_ITER_W = 6
);
    logic                in_valid;
    logic                in_ready;
    logic [p_WIDTH-1:0]  in_x;
    logic [p_WIDTH-1:0]  in_y;
    logic [p_WIDTH-1:0]  in_z;
    logic                in_system;
    logic                in_mode;
    logic [p_ITER_W-1:0] in_num_iter;

    logic                core_load;
    logic [p_WIDTH-1:0]  core_x_init;
    logic [p_WIDTH-1:0]  core_y_init;
    logic [p_WIDTH-1:0]  core_z_init;
    logic                core_system;
    logic                core_mode;
    logic                core_en;
    logic [p_ITER_W-1:0] core_shift;
    logic [p_WIDTH-1:0]  core_x;
    logic [p_WIDTH-1:0]  core_y;
    logic [p_WIDTH-1:0]  core_z;
    logic                core_x_ov;
    logic                core_y_ov;
    logic                core_z_ov;

    logic                out_valid;
    logic                out_ready;
    logic [p_WIDTH-1:0]  out_x;
    logic [p_WIDTH-1:0]  out_y;
    logic [p_WIDTH-1:0]  out_z;
    logic [2:0]          out_ov;
    logic [p_ITER_W-1:0] out_ov_iter;

    modport master (
        input  in_valid, in_x, in_y, in_z, in_system, in_mode, in_num_iter,
        output in_ready,
        output core_load, core_x_init, core_y_init, core_z_init,
        output core_system, core_mode, core_en, core_shift,
        input  core_x, core_y, core_z, core_x_ov, core_y_ov, core_z_ov,
        output out_valid, out_x, out_y, out_z, out_ov, out_ov_iter,
        input  out_ready
    );

    modport slave (
        output in_valid, in_x, in_y, in_z, in_system, in_mode, in_num_iter,
        input  in_ready,
        input  core_load, core_x_init, core_y_init, core_z_init,
        input  core_system, core_mode, core_en, core_shift,
        output core_x, core_y, core_z, core_x_ov, core_y_ov, core_z_ov,
        input  out_valid, out_x, out_y, out_z, out_ov, out_ov_iter,
        output out_ready
    );
endinterface

// File: rtl/cordic_iter_controller.sv
// Sequences one CORDIC job: loads the core, issues N shift-indexed steps,
// tracks sticky overflow and hands the final vector to the consumer.
module cordic_iter_controller #(
    parameter int p_WIDTH  = 32,
    parameter int p_ITER_W = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    cordic_iter_controller_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_ITER = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state_r, state_next_s;
    logic                in_ready_r, core_load_r, core_en_r, out_valid_r;
    logic [p_WIDTH-1:0]  x_init_r, y_init_r, z_init_r;
    logic                system_r, mode_r;
    logic [p_ITER_W-1:0] num_iter_r, k_r, shift_r, k_d_r, ov_iter_r;
    logic                rep_done_r, en_d_r;
    logic [2:0]          ov_r;
    logic [p_WIDTH-1:0]  out_x_r, out_y_r, out_z_r;
    logic [2:0]          out_ov_r;
    logic [p_ITER_W-1:0] out_ov_iter_r;

    logic                accept_s, rep_next_s;
    logic [p_ITER_W-1:0] shift_adv_s, ov_iter_acc_s;
    logic [2:0]          ov_now_s, ov_acc_s;

    // Hyperbolic indices of the form (3^j-1)/2 must be issued twice for convergence
    function automatic logic is_rep_idx(input logic [p_ITER_W-1:0] s);
        return (s == p_ITER_W'(4)) || (s == p_ITER_W'(13)) || (s == p_ITER_W'(40));
    endfunction

    assign accept_s = (state_r == S_IDLE) && bus.in_valid;

    // Next-state decode
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: if (bus.in_valid) state_next_s = S_LOAD; else state_next_s = S_IDLE;
            S_LOAD: if (num_iter_r == '0) state_next_s = S_DONE; else state_next_s = S_ITER;
            S_ITER: if (k_r == num_iter_r - p_ITER_W'(1)) state_next_s = S_DONE;
                    else state_next_s = S_ITER;
            S_DONE: if (out_valid_r && bus.out_ready) state_next_s = S_IDLE;
                    else state_next_s = S_DONE;
            default: state_next_s = S_IDLE;
        endcase
    end

    // Shift schedule advance and overflow accumulation for the step just sampled
    always_comb begin
        shift_adv_s   = shift_r;
        rep_next_s    = 1'b0;
        ov_now_s      = 3'b000;
        ov_iter_acc_s = ov_iter_r;
        if (system_r) begin
            shift_adv_s = shift_r + p_ITER_W'(1);
        end else if (is_rep_idx(shift_r) && !rep_done_r) begin
            rep_next_s = 1'b1;
        end else if (shift_r == {p_ITER_W{1'b1}}) begin
            shift_adv_s = shift_r;
        end else begin
            shift_adv_s = shift_r + p_ITER_W'(1);
        end
        if (en_d_r) begin
            ov_now_s = {bus.core_x_ov, bus.core_y_ov, bus.core_z_ov};
        end else begin
            ov_now_s = 3'b000;
        end
        ov_acc_s = ov_r | ov_now_s;
        if ((ov_r == 3'b000) && (ov_now_s != 3'b000)) begin
            ov_iter_acc_s = k_d_r;
        end else begin
            ov_iter_acc_s = ov_iter_r;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_r <= S_IDLE;
        else     state_r <= state_next_s;
    end

    // Registered handshake and core strobes, decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b1;
            core_load_r <= 1'b0;
            core_en_r   <= 1'b0;
        end else begin
            in_ready_r  <= (state_next_s == S_IDLE);
            core_load_r <= (state_next_s == S_LOAD);
            core_en_r   <= (state_next_s == S_ITER);
        end
    end

    // Job latch, step counter and shift index
    always_ff @(posedge clk) begin
        if (rst) begin
            x_init_r   <= '0;
            y_init_r   <= '0;
            z_init_r   <= '0;
            system_r   <= 1'b0;
            mode_r     <= 1'b0;
            num_iter_r <= '0;
            k_r        <= '0;
            shift_r    <= '0;
            rep_done_r <= 1'b0;
        end else if (accept_s) begin
            x_init_r   <= bus.in_x;
            y_init_r   <= bus.in_y;
            z_init_r   <= bus.in_z;
            system_r   <= bus.in_system;
            mode_r     <= bus.in_mode;
            num_iter_r <= bus.in_num_iter;
            k_r        <= '0;
            shift_r    <= bus.in_system ? '0 : p_ITER_W'(1);
            rep_done_r <= 1'b0;
        end else if (state_r == S_ITER) begin
            k_r        <= k_r + p_ITER_W'(1);
            shift_r    <= shift_adv_s;
            rep_done_r <= rep_next_s;
        end
    end

    // Core overflow flags arrive one cycle after each step, so the step index is delayed too
    always_ff @(posedge clk) begin
        if (rst) begin
            en_d_r    <= 1'b0;
            k_d_r     <= '0;
            ov_r      <= 3'b000;
            ov_iter_r <= '0;
        end else begin
            en_d_r <= (state_r == S_ITER);
            k_d_r  <= k_r;
            if (accept_s) begin
                ov_r      <= 3'b000;
                ov_iter_r <= '0;
            end else begin
                ov_r      <= ov_acc_s;
                ov_iter_r <= ov_iter_acc_s;
            end
        end
    end

    // Result capture on the first DONE cycle, then hold until the consumer takes it
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r   <= 1'b0;
            out_x_r       <= '0;
            out_y_r       <= '0;
            out_z_r       <= '0;
            out_ov_r      <= 3'b000;
            out_ov_iter_r <= '0;
        end else if ((state_r == S_DONE) && !out_valid_r) begin
            out_valid_r   <= 1'b1;
            out_x_r       <= bus.core_x;
            out_y_r       <= bus.core_y;
            out_z_r       <= bus.core_z;
            out_ov_r      <= ov_acc_s;
            out_ov_iter_r <= ov_iter_acc_s;
        end else if ((state_r == S_DONE) && bus.out_ready) begin
            out_valid_r   <= 1'b0;
        end
    end

    assign bus.in_ready    = in_ready_r;
    assign bus.core_load   = core_load_r;
    assign bus.core_en     = core_en_r;
    assign bus.core_x_init = x_init_r;
    assign bus.core_y_init = y_init_r;
    assign bus.core_z_init = z_init_r;
    assign bus.core_system = system_r;
    assign bus.core_mode   = mode_r;
    assign bus.core_shift  = shift_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_x       = out_x_r;
    assign bus.out_y       = out_y_r;
    assign bus.out_z       = out_z_r;
    assign bus.out_ov      = out_ov_r;
    assign bus.out_ov_iter = out_ov_iter_r;
endmodule
